// File: rtl/simd_ins_sequencer_if.sv
// Port bundle between the SIMD instruction sequencer and its surroundings:
// PS control (start/busy/done/err), instruction BRAM, operand/result BRAM ports.
interface simd_ins_sequencer_if #(
    parameter int ADDR_WIDTH     = 10,
    parameter int INS_ADDR_WIDTH = 11,
    parameter int INS_WIDTH      = 64
);
    logic                      start;
    logic [INS_ADDR_WIDTH-1:0] start_pc;
    logic                      busy;
    logic                      done;
    logic                      err;
    logic                      ins_rd_en;
    logic [INS_ADDR_WIDTH-1:0] ins_addr;
    logic [INS_WIDTH-1:0]      ins_data;
    logic                      a_rd_en;
    logic [ADDR_WIDTH-1:0]     a_rd_addr;
    logic                      b_rd_en;
    logic [ADDR_WIDTH-1:0]     b_rd_addr;
    logic [3:0]                alu_op;
    logic                      r_wr_en;
    logic [INS_ADDR_WIDTH-1:0] r_wr_addr;
    logic [2:0]                dbg_state;

    // Handshake: start is a one-cycle request taken only while busy is low
    // (there is no separate ready); start_pc is sampled in that same cycle.
    // ins_data must be valid exactly one cycle after ins_rd_en, BRAM-style.
    // master = the sequencer; slave = PS, instruction BRAM and the PE/BRAM side.
    modport master (
        input  start, start_pc, ins_data,
        output busy, done, err, ins_rd_en, ins_addr,
               a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
               alu_op, r_wr_en, r_wr_addr, dbg_state
    );

    modport slave (
        output start, start_pc, ins_data,
        input  busy, done, err, ins_rd_en, ins_addr,
               a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
               alu_op, r_wr_en, r_wr_addr, dbg_state
    );
endinterface

// File: rtl/simd_ins_sequencer.sv
// Fetch/decode/issue control for the 4-lane SIMD datapath: streams operand rows
// from BRAM A/B and schedules the matching BRAM R write-backs PIPE_LAT cycles later.
module simd_ins_sequencer #(
    parameter int ADDR_WIDTH     = 10,
    parameter int INS_ADDR_WIDTH = 11,
    parameter int INS_WIDTH      = 64,
    parameter int PIPE_LAT       = 3
) (
    input  logic                 clk,
    input  logic                 rstn,
    simd_ins_sequencer_if.master bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_ISSUE  = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_MIN  = 4'h5;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam int CNT_W   = 12;
    localparam int OPC_MSB = INS_WIDTH - 1;
    localparam int CNT_MSB = OPC_MSB - 4;
    localparam int A_MSB   = CNT_MSB - CNT_W;
    localparam int B_MSB   = A_MSB - ADDR_WIDTH;
    localparam int R_MSB   = B_MSB - ADDR_WIDTH;
    localparam int RES_MSB = R_MSB - INS_ADDR_WIDTH;
    localparam int DW      = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    logic [2:0]                state_q,  state_d;
    logic [INS_ADDR_WIDTH-1:0] pc_q,     pc_d;
    logic                      err_q,    err_d;
    logic [3:0]                alu_op_q, alu_op_d;
    logic [CNT_W-1:0]          count_q,  count_d;
    logic [CNT_W-1:0]          row_q,    row_d;
    logic [ADDR_WIDTH-1:0]     a_base_q, a_base_d;
    logic [ADDR_WIDTH-1:0]     b_base_q, b_base_d;
    logic [INS_ADDR_WIDTH-1:0] r_base_q, r_base_d;
    logic [DW-1:0]             drain_q,  drain_d;

    // Write-back delay line; the tail stage drives BRAM R directly.
    logic [PIPE_LAT-1:0]       pipe_vld_q;
    logic [INS_ADDR_WIDTH-1:0] pipe_addr_q [PIPE_LAT];

    logic [3:0]                dec_op;
    logic [CNT_W-1:0]          dec_count;
    logic [ADDR_WIDTH-1:0]     dec_a_base;
    logic [ADDR_WIDTH-1:0]     dec_b_base;
    logic [INS_ADDR_WIDTH-1:0] dec_r_base;
    logic                      unused_reserved;

    logic                      fetch;
    logic                      issue;
    logic                      pc_last;
    logic                      drain_last;
    logic                      row_last;
    logic [INS_ADDR_WIDTH-1:0] r_row_addr;

    assign dec_op          = bus.ins_data[OPC_MSB -: 4];
    assign dec_count       = bus.ins_data[CNT_MSB -: CNT_W];
    assign dec_a_base      = bus.ins_data[A_MSB -: ADDR_WIDTH];
    assign dec_b_base      = bus.ins_data[B_MSB -: ADDR_WIDTH];
    assign dec_r_base      = bus.ins_data[R_MSB -: INS_ADDR_WIDTH];
    assign unused_reserved = ^bus.ins_data[RES_MSB:0];

    assign fetch      = (state_q == S_FETCH);
    assign issue      = (state_q == S_ISSUE);
    assign pc_last    = &pc_q;
    assign drain_last = (drain_q == DW'(PIPE_LAT - 1));
    assign row_last   = (row_q == count_q - CNT_W'(1));
    assign r_row_addr = r_base_q + row_q[INS_ADDR_WIDTH-1:0];

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        err_d    = err_q;
        alu_op_d = alu_op_q;
        count_d  = count_q;
        row_d    = row_q;
        a_base_d = a_base_q;
        b_base_d = b_base_q;
        r_base_d = r_base_q;
        drain_d  = drain_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    pc_d    = bus.start_pc;
                    err_d   = 1'b0;
                    state_d = S_FETCH;
                end
            end

            S_FETCH: state_d = S_DECODE;

            S_DECODE: begin
                count_d  = dec_count;
                a_base_d = dec_a_base;
                b_base_d = dec_b_base;
                r_base_d = dec_r_base;
                row_d    = '0;
                if (dec_op == OP_HALT) begin
                    state_d = S_DONE;
                end else if (dec_op > OP_MIN) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if ((dec_op == OP_NOP) || (dec_count == '0)) begin
                    // Nothing to issue: step straight to the next instruction.
                    if (pc_last) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        pc_d    = pc_q + INS_ADDR_WIDTH'(1);
                        state_d = S_FETCH;
                    end
                end else begin
                    alu_op_d = dec_op;
                    state_d  = S_ISSUE;
                end
            end

            S_ISSUE: begin
                if (row_last) begin
                    drain_d = '0;
                    state_d = S_DRAIN;
                end else begin
                    row_d = row_q + CNT_W'(1);
                end
            end

            S_DRAIN: begin
                // alu_op stays put until the last write-back has left the PEs.
                if (drain_last) begin
                    alu_op_d = '0;
                    if (pc_last) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        pc_d    = pc_q + INS_ADDR_WIDTH'(1);
                        state_d = S_FETCH;
                    end
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end

            S_DONE: state_d = S_IDLE;

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            err_q    <= 1'b0;
            alu_op_q <= '0;
            count_q  <= '0;
            row_q    <= '0;
            a_base_q <= '0;
            b_base_q <= '0;
            r_base_q <= '0;
            drain_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            err_q    <= err_d;
            alu_op_q <= alu_op_d;
            count_q  <= count_d;
            row_q    <= row_d;
            a_base_q <= a_base_d;
            b_base_q <= b_base_d;
            r_base_q <= r_base_d;
            drain_q  <= drain_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pipe_vld_q <= '0;
            for (int k = 0; k < PIPE_LAT; k++) begin
                pipe_addr_q[k] <= '0;
            end
        end else begin
            pipe_vld_q[0]  <= issue;
            pipe_addr_q[0] <= issue ? r_row_addr : '0;
            for (int k = 1; k < PIPE_LAT; k++) begin
                pipe_vld_q[k]  <= pipe_vld_q[k-1];
                pipe_addr_q[k] <= pipe_addr_q[k-1];
            end
        end
    end

    // Addresses are forced to zero outside their enable so idle buses stay quiet.
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.err       = err_q;
    assign bus.ins_rd_en = fetch;
    assign bus.ins_addr  = fetch ? pc_q : '0;
    assign bus.a_rd_en   = issue;
    assign bus.a_rd_addr = issue ? (a_base_q + row_q[ADDR_WIDTH-1:0]) : '0;
    assign bus.b_rd_en   = issue;
    assign bus.b_rd_addr = issue ? (b_base_q + row_q[ADDR_WIDTH-1:0]) : '0;
    assign bus.alu_op    = alu_op_q;
    assign bus.r_wr_en   = pipe_vld_q[PIPE_LAT-1];
    assign bus.r_wr_addr = pipe_addr_q[PIPE_LAT-1];
    assign bus.dbg_state = state_q;

endmodule

// File: doc/simd_ins_sequencer.md
Name: simd_ins_sequencer

Overview:
- Control unit for the 4-lane SIMD datapath.
- On a start pulse from the PS, it fetches 64-bit instructions from the instruction BRAM, starting at a programmable PC.
- For each instruction it decodes the fields and streams row addresses to BRAM A and BRAM B. It drives the ALU opcode to all PEs and schedules the matching write-back to BRAM R after the fixed PE pipeline latency.
- It sits between the instruction BRAM and the operand/result BRAM ports inside datapath_top. It signals busy/done/err back to the PS.

Parameters:
- ADDR_WIDTH, 10, operand BRAM (A/B) address width.
- INS_ADDR_WIDTH, 11, instruction and result BRAM address width.
- INS_WIDTH, 64, instruction word width.
- PIPE_LAT, 3, cycles from a_rd_en/b_rd_en to the corresponding PE result being valid (min 1).

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to run the program; ignored while busy
- start_pc  in  INS_ADDR_WIDTH  first instruction address, sampled with start
- busy  out  1  high from the cycle after start is accepted through the DONE cycle
- done  out  1  one-cycle pulse on program end (HALT or error)
- err  out  1  sticky error flag, cleared on the next accepted start
- ins_rd_en  out  1  instruction BRAM read enable
- ins_addr  out  INS_ADDR_WIDTH  instruction BRAM address (PC)
- ins_data  in  INS_WIDTH  instruction BRAM data, valid 1 cycle after ins_rd_en
- a_rd_en  out  1  BRAM A read enable
- a_rd_addr  out  ADDR_WIDTH  BRAM A row address
- b_rd_en  out  1  BRAM B read enable
- b_rd_addr  out  ADDR_WIDTH  BRAM B row address
- alu_op  out  4  opcode broadcast to all PEs
- r_wr_en  out  1  BRAM R write enable
- r_wr_addr  out  INS_ADDR_WIDTH  BRAM R row address

Behaviour:
- Reset: all outputs are 0; state IDLE; PC 0; pipeline valid bits cleared. Reset mid-program aborts immediately, with no done pulse.
- Instruction fields:
  - opcode [63:60]
  - count [59:48], number of rows
  - a_base [47:38]
  - b_base [37:28]
  - r_base [27:17]
  - [16:0] reserved, ignored
- Opcodes:
  - 0 NOP
  - 1 ADD
  - 2 SUB
  - 3 MUL
  - 4 MAX
  - 5 MIN
  - F HALT
  - 6-E illegal
- FSM states: IDLE, FETCH, DECODE, ISSUE, DRAIN, DONE.
- IDLE: start=1 latches PC=start_pc, clears err, goes to FETCH.
- FETCH (1 cycle): ins_rd_en=1, ins_addr=PC.
- DECODE (1 cycle): latch fields from ins_data, then branch on the opcode:
  - HALT goes to DONE.
  - Illegal opcode sets err and goes to DONE.
  - NOP, or count==0, sets PC+1 and goes to FETCH.
  - Otherwise alu_op<=opcode and go to ISSUE.
- ISSUE (count cycles):
  - a_rd_en=b_rd_en=1.
  - On row i, a_rd_addr=a_base+i and b_rd_addr=b_base+i, each modulo 2^ADDR_WIDTH (wrap, no error).
  - Each issued row pushes {valid, r_base+i mod 2^INS_ADDR_WIDTH} into a PIPE_LAT-deep shift register.
  - r_wr_en/r_wr_addr come from the shift-register tail, so r_wr_en rises exactly PIPE_LAT cycles after each a_rd_en.
- DRAIN (PIPE_LAT cycles): no new reads; alu_op held; the last write-back occurs in the final DRAIN cycle; then PC+1 and go to FETCH.
- alu_op is held constant from DECODE through the end of DRAIN, so instructions never overlap in the PEs.
- PC overflow: an increment past 2^INS_ADDR_WIDTH-1 without a HALT sets err and goes to DONE. No wrap.
- DONE (1 cycle): done=1, busy=1, then IDLE with busy=0.
- start asserted while busy has no effect. start in the same cycle as done is also ignored, because the FSM is not yet IDLE.

Test Plan:
- ADD, count=3, a_base=10, b_base=20, r_base=100 at PC0; HALT at PC1; PIPE_LAT=3; start at cycle 0:
  - ins_rd_en at cycle 1.
  - a_rd_addr 10,11,12 and b_rd_addr 20,21,22 at cycles 3-5.
  - r_wr_addr 100,101,102 at cycles 6-8.
  - FETCH at cycle 9; done at cycle 11; busy high for cycles 1-11; err=0.
- Wrap: a_base=1022, count=4 gives a_rd_addr 1022,1023,0,1 with no err. r_base=2046 gives r_wr_addr 2046,2047,0,1.
- Illegal opcode 7 at PC0: done pulse 3 cycles after start; err=1; no a_rd_en/r_wr_en ever asserted. The next start clears err.
- NOP followed by count=0 MUL, then HALT: no operand reads; done after 3 fetch/decode pairs (cycle 7); alu_op stays 0.
- start held high during a run: only one run occurs. Reset asserted mid-ISSUE: all outputs are 0 asynchronously, FSM returns to IDLE, and no done pulse is produced.
- start_pc=2047 with MUL count=1: the instruction executes fully, then PC overflow sets err and done pulses.
